// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for the decoder. It holds the program counter,
//   addresses a synchronous program ROM (1-cycle read latency) and registers
//   each returned word into the instruction register that feeds the decoder.
//
//   Redirects come from the decoder's registered jmpEnable/branchEnable
//   strobes. Those strobes are one cycle behind the word that caused them, so
//   this block keeps its own one-cycle-delayed copy of the instruction word
//   and address (exWord/exPc). Targets are computed from that copy, which is
//   what lines them up with the enables.
//
// Ports
//   clk           in   1   single clock, all state on posedge
//   reset         in   1   synchronous, active-high
//   jmpEnable     in   1   decoder jump strobe (wins over branch)
//   branchEnable  in   1   decoder taken-branch strobe
//   stall         in   1   hold fetch; only honoured in RUN
//   romData       in   16  ROM read data for the address issued last cycle
//   romAddr       out  10  ROM read address (combinational)
//   instr         out  16  instruction word to decoder
//   instrPc       out  10  address of the word in the instruction register
//   instrValid    out  1   instr carries a real, non-squashed instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [9:0]  RESET_PC  = 10'h000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jmpEnable,
    input  logic        branchEnable,
    input  logic        stall,
    input  logic [15:0] romData,
    output logic [9:0]  romAddr,
    output logic [15:0] instr,
    output logic [9:0]  instrPc,
    output logic        instrValid
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  pc;        // next fetch address
    logic [9:0]  pcF;       // address issued to the ROM last cycle
    logic [15:0] instrReg;
    logic        validReg;

    // Only the low ten bits of the delayed word ever feed a target, so only
    // those are kept.
    logic [9:0]  exWord;
    logic [9:0]  exPc;

    logic        redirect;
    logic        hold;
    logic [9:0]  target;

    assign redirect = jmpEnable | branchEnable;

    // A redirect overrides a stall, so the hold condition excludes it.
    assign hold = (state == RUN) & stall & ~redirect;

    // Branch target is page-relative: the page bits come from the branch's
    // own address and the low bits never carry into them.
    always_comb begin
        target = {exPc[9:6], exWord[5:0]};
        if (jmpEnable)
            target = exWord;
    end

    // While held, re-read the pending address so the word that would have
    // arrived this cycle is presented again next cycle.
    assign romAddr = hold ? pcF : pc;

    // The word behind a jump/branch is killed combinationally in the same
    // cycle the strobe arrives; the two registered NOP slots follow.
    assign instr      = redirect ? NOP_INSTR : instrReg;
    assign instrValid = validReg & ~redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pcF      <= RESET_PC;
            instrReg <= NOP_INSTR;
            instrPc  <= 10'h000;
            validReg <= 1'b0;
            exWord   <= NOP_INSTR[9:0];
            exPc     <= 10'h000;
        end else begin
            // The decoder registers instr on this same edge; keep a matching
            // copy so a strobe next cycle sees the word that raised it.
            exWord <= instrReg[9:0];
            exPc   <= instrPc;

            if (redirect) begin
                pc       <= target;
                pcF      <= pc;
                instrReg <= NOP_INSTR;
                validReg <= 1'b0;
                state    <= FLUSH;
            end else begin
                case (state)
                    RUN: begin
                        if (!stall) begin
                            pc       <= pc + 10'd1;
                            pcF      <= pc;
                            instrReg <= romData;
                            instrPc  <= pcF;
                            validReg <= 1'b1;
                        end
                    end
                    // BOOT and FLUSH: romData belongs to no useful address
                    // yet, so issue the first fetch and present a NOP.
                    default: begin
                        pc       <= pc + 10'd1;
                        pcF      <= pc;
                        instrReg <= NOP_INSTR;
                        validReg <= 1'b0;
                        state    <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        jmpEnable;
    logic        branchEnable;
    logic        stall;
    logic [15:0] romData;
    logic [9:0]  romAddr;
    logic [15:0] instr;
    logic [9:0]  instrPc;
    logic        instrValid;

    fetch_unit #(.RESET_PC(10'h000), .NOP_INSTR(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .jmpEnable    (jmpEnable),
        .branchEnable (branchEnable),
        .stall        (stall),
        .romData      (romData),
        .romAddr      (romAddr),
        .instr        (instr),
        .instrPc      (instrPc),
        .instrValid   (instrValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [1024];
    always @(posedge clk) romData <= rom[romAddr];

    typedef struct {
        logic [9:0]  pc;
        logic [15:0] word;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every instruction the decoder accepts must be the next
    // expected (address, word) pair.
    always @(negedge clk) begin
        if (!reset && instrValid && !stall) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr: got pc=%0h word=%0h expected none", instrPc, instr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (instrPc !== e.pc || instr !== e.word) begin
                    errors++;
                    $display("FAIL instr_stream: got pc=%0h word=%0h expected pc=%0h word=%0h",
                             instrPc, instr, e.pc, e.word);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int start, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.pc   = 10'(start + k);
            e.word = rom[e.pc];
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        jmpEnable    = 1'b0;
        branchEnable = 1'b0;
        reset        = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        #1;
    endtask

    // Returns at the negedge where the given address is valid in instr.
    task automatic wait_pc(input logic [9:0] p);
        bit found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (instrValid && instrPc == p) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_pc_timeout: got no valid instrPc, expected %0h", p);
        end
    endtask

    // Wait for the scoreboard to drain, then freeze fetch with stall.
    task automatic wait_empty();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (q.size() == 0) done = 1;
            else step();
        end
        stall = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'(16'h1000 + i);
        rom[10]     = 16'h20C8;   // jump to 0C8 (branch reading gives 008)
        rom[10'h142] = 16'h503F;  // branch low bits 3F

        reset = 1'b1; jmpEnable = 1'b0; branchEnable = 1'b0; stall = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state and first-fetch latency
        push_range(0, 10);
        chk("boot_romAddr", romAddr, 10'h000);
        chk("boot_instr", instr, 16'h0000);
        chk("boot_valid", instrValid, 1'b0);
        chk("boot_instrPc", instrPc, 10'h000);
        step();
        chk("c1_romAddr", romAddr, 10'h001);
        chk("c1_valid", instrValid, 1'b0);
        chk("c1_instr", instr, 16'h0000);
        step();
        chk("c2_romAddr", romAddr, 10'h002);
        chk("c2_valid", instrValid, 1'b1);

        // Stall three cycles while 1005 is presented
        wait_pc(10'h004);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_instr", instr, 16'h1005);
            chk("stall_instrPc", instrPc, 10'h005);
            chk("stall_romAddr", romAddr, 10'h006);
            step();
        end
        stall = 1'b0;
        wait_empty();

        // Jump: three NOP slots, then target 0C8
        do_reset();
        push_range(0, 11);
        wait_pc(10'd10);
        push_range(10'h0C8, 4);
        step();
        jmpEnable = 1'b1;
        #1;
        chk("jmp_squash_instr", instr, 16'h0000);
        chk("jmp_squash_valid", instrValid, 1'b0);
        step();
        jmpEnable = 1'b0;
        #1;
        chk("jmp_flush_instr", instr, 16'h0000);
        chk("jmp_flush_romAddr", romAddr, 10'h0C8);
        step();
        chk("jmp_slot3_instr", instr, 16'h0000);
        chk("jmp_slot3_valid", instrValid, 1'b0);
        chk("jmp_slot3_romAddr", romAddr, 10'h0C9);
        wait_empty();

        // Jump and branch together, during a stall: jump wins, not lost
        do_reset();
        push_range(0, 11);
        wait_pc(10'd10);
        push_range(10'h0C8, 4);
        step();
        jmpEnable = 1'b1; branchEnable = 1'b1; stall = 1'b1;
        #1;
        chk("both_squash_instr", instr, 16'h0000);
        step();
        jmpEnable = 1'b0; branchEnable = 1'b0; stall = 1'b0;
        #1;
        chk("both_flush_romAddr", romAddr, 10'h0C8);
        wait_empty();

        // Taken branch at 142 -> 17F
        do_reset();
        push_range(0, 10'h143);
        wait_pc(10'h142);
        push_range(10'h17F, 4);
        step();
        branchEnable = 1'b1;
        #1;
        chk("br_squash_instr", instr, 16'h0000);
        step();
        branchEnable = 1'b0;
        #1;
        chk("br_flush_romAddr", romAddr, 10'h17F);
        wait_empty();

        // Branch not taken: straight through 142 into 143
        do_reset();
        push_range(0, 10'h146);
        wait_empty();

        // Wrap: jump to 3FE, fetch 3FE,3FF,000
        rom[10] = 16'h03FE;
        do_reset();
        push_range(0, 11);
        wait_pc(10'd10);
        push_range(10'h3FE, 4);
        step();
        jmpEnable = 1'b1;
        step();
        jmpEnable = 1'b0;
        #1;
        chk("wrap_romAddr0", romAddr, 10'h3FE);
        step();
        chk("wrap_romAddr1", romAddr, 10'h3FF);
        step();
        chk("wrap_romAddr2", romAddr, 10'h000);
        wait_empty();

        // Reset while flushing: back to BOOT, redirect forgotten
        rom[10] = 16'h20C8;
        do_reset();
        push_range(0, 11);
        wait_pc(10'd10);
        step();
        jmpEnable = 1'b1;
        step();
        jmpEnable = 1'b0;
        #1;
        chk("rstflush_romAddr", romAddr, 10'h0C8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        push_range(0, 6);
        chk("rstflush_boot_romAddr", romAddr, 10'h000);
        chk("rstflush_boot_valid", instrValid, 1'b0);
        chk("rstflush_boot_instr", instr, 16'h0000);
        step();
        chk("rstflush_c1_romAddr", romAddr, 10'h001);
        wait_empty();

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
